// File: rtl/ladybird_prefetch_unit_pkg.sv
// ladybird_config: shared configuration for the Ladybird fetch path.
//   XLEN            - architectural word width
//   PREFETCH_DEPTH  - default prefetch buffer depth / max outstanding MMU requests
//   fetch_entry_t   - one buffered fetch result {pc, inst}
//   pf_state_t      - prefetcher control state
package ladybird_config;

    localparam int unsigned XLEN           = 32;
    localparam int unsigned PREFETCH_DEPTH = 4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    typedef enum logic {
        PF_IDLE,
        PF_RUN
    } pf_state_t;

endpackage

// File: rtl/ladybird_prefetch_unit_fetch_fifo.sv
// ladybird_fetch_fifo: synchronous FIFO of fetch_entry_t.
//   clk, rst  - clock, synchronous active-high reset (storage cleared to zero)
//   i_push    - write i_entry (accepted when not full, or when full with a pop)
//   i_entry   - entry to write
//   i_pop     - remove head (ignored when empty)
//   i_flush   - discard all entries; wins over a push in the same cycle
//   o_head    - current head entry
//   o_count   - number of stored entries
//   o_empty   - no entries stored
//   o_full    - DEPTH entries stored
module ladybird_fetch_fifo
    import ladybird_config::*;
#(
    parameter int unsigned DEPTH = PREFETCH_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_push,
    input  fetch_entry_t                 i_entry,
    input  logic                         i_pop,
    input  logic                         i_flush,
    output fetch_entry_t                 o_head,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_empty,
    output logic                         o_full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    fetch_entry_t    r_mem [DEPTH];
    logic [AW-1:0]   r_wr;
    logic [AW-1:0]   r_rd;
    logic [CW-1:0]   r_count;
    logic            w_push;
    logic            w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd];

    assign w_pop  = i_pop & ~o_empty;
    // When full, the slot being popped is the one written, so push+pop is safe.
    assign w_push = i_push & (~o_full | w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= i_entry;
                r_wr        <= r_wr + AW'(1);
            end
            if (w_pop) begin
                r_rd <= r_rd + AW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

endmodule

// File: rtl/ladybird_prefetch_unit.sv
// ladybird_prefetch_unit: sequential instruction prefetcher between fetch and MMU.
//   clk, rst               - clock, synchronous active-high reset
//   redirect_valid/_pc     - restart fetch at redirect_pc (low two bits ignored)
//   halt                   - suppress new MMU requests; in-flight ones still land
//   pc, pc_valid, pc_ready - MMU request channel (pc holds until accepted)
//   inst, inst_valid       - MMU response, in order, one per accepted request
//   o_pc, o_inst, o_valid  - head of the prefetch buffer toward decode
//   o_ready                - decode accepts the head entry
module ladybird_prefetch_unit
    import ladybird_config::*;
#(
    parameter int unsigned DEPTH = PREFETCH_DEPTH
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            halt,
    output logic [XLEN-1:0] pc,
    output logic            pc_valid,
    input  logic            pc_ready,
    input  logic [XLEN-1:0] inst,
    input  logic            inst_valid,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_inst,
    output logic            o_valid,
    input  logic            o_ready
);

    localparam int unsigned CW  = $clog2(DEPTH+1);
    localparam logic [CW:0] LIM = (CW+1)'(DEPTH);

    pf_state_t       r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_resp_pc;
    logic [CW-1:0]   r_inflight;
    logic [CW-1:0]   r_drop;

    logic [XLEN-1:0] w_redirect_pc;
    logic [CW-1:0]   w_count;
    logic [CW:0]     w_occupancy;
    logic            w_empty;
    logic            w_full;
    logic            w_issue;
    logic            w_resp;
    logic            w_push;
    logic            w_pop;
    fetch_entry_t    w_head;
    fetch_entry_t    w_push_entry;

    assign w_redirect_pc = redirect_pc & ~XLEN'(3);
    assign w_occupancy   = {1'b0, w_count} + {1'b0, r_inflight};

    // Credit: every outstanding request owns a buffer slot, so responses never overflow.
    assign pc_valid = (r_state == PF_RUN) & ~halt & ~redirect_valid & (w_occupancy < LIM);
    assign pc       = r_pc;
    assign w_issue  = pc_valid & pc_ready;

    // Responses with nothing outstanding (e.g. straggling across reset) are ignored.
    assign w_resp   = inst_valid & (r_inflight != '0);
    assign w_push   = w_resp & (r_drop == '0) & ~redirect_valid;
    assign w_pop    = o_valid & o_ready;

    assign w_push_entry.pc   = r_resp_pc;
    assign w_push_entry.inst = inst;

    assign o_valid = ~w_empty;
    assign o_pc    = w_head.pc;
    assign o_inst  = w_head.inst;

    ladybird_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_entry (w_push_entry),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .o_head  (w_head),
        .o_count (w_count),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= PF_IDLE;
            r_pc       <= '0;
            r_resp_pc  <= '0;
            r_inflight <= '0;
            r_drop     <= '0;
        end else if (redirect_valid) begin
            r_state    <= PF_RUN;
            r_pc       <= w_redirect_pc;
            r_resp_pc  <= w_redirect_pc;
            r_inflight <= r_inflight - CW'(w_resp);
            // Every request still outstanding after this cycle is stale. r_inflight
            // already includes words pending drop, so this also covers back-to-back
            // redirects without over-counting.
            r_drop     <= r_inflight - CW'(w_resp);
        end else begin
            if (w_issue) begin
                r_pc <= r_pc + XLEN'(4);
            end
            if (w_push) begin
                r_resp_pc <= r_resp_pc + XLEN'(4);
            end
            if (w_resp && (r_drop != '0)) begin
                r_drop <= r_drop - CW'(1);
            end
            r_inflight <= r_inflight + CW'(w_issue) - CW'(w_resp);
        end
    end

    a_credit: assert property (@(posedge clk) disable iff (rst) w_occupancy <= LIM);
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(w_push && w_full && !w_pop));

endmodule

// File: tb/tb_ladybird_prefetch_unit.sv
module tb_ladybird_prefetch_unit;
    import ladybird_config::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        halt = 1'b0;
    logic [31:0] pc;
    logic        pc_valid;
    logic        pc_ready = 1'b0;
    logic [31:0] inst = '0;
    logic        inst_valid = 1'b0;
    logic [31:0] o_pc;
    logic [31:0] o_inst;
    logic        o_valid;
    logic        o_ready = 1'b0;

    always #5 clk = ~clk;

    ladybird_prefetch_unit #(.DEPTH(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .pc             (pc),
        .pc_valid       (pc_valid),
        .pc_ready       (pc_ready),
        .inst           (inst),
        .inst_valid     (inst_valid),
        .o_pc           (o_pc),
        .o_inst         (o_inst),
        .o_valid        (o_valid),
        .o_ready        (o_ready)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned cyc      = 0;
    int unsigned mmu_lat  = 1;
    int unsigned n_issued = 0;
    int unsigned n_deliv  = 0;

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
    } mmu_req_t;

    mmu_req_t    mmu_q[$];
    logic [31:0] exp_q[$];       // expected delivery PCs, in order
    logic [31:0] model_pc = '0;  // next PC the fetch stream should request

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5a5a_1234;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    always @(posedge clk) cyc++;

    // MMU model: fixed latency, in order, one response per cycle at most.
    always @(posedge clk) begin
        #1;
        inst_valid = 1'b0;
        if (mmu_q.size() > 0 && mmu_q[0].due <= cyc) begin
            inst_valid = 1'b1;
            inst       = mem_word(mmu_q[0].addr);
            void'(mmu_q.pop_front());
        end
    end

    // Scoreboard / monitor.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            mmu_q.delete();
        end else begin
            if (o_valid && o_ready) begin
                n_deliv++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_delivery: got o_pc=%h, required no delivery", o_pc);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    chk("deliv_pc", o_pc, e);
                    chk("deliv_inst", o_inst, mem_word(e));
                end
            end
            if (halt) chk("halt_blocks_issue", {31'b0, pc_valid}, 32'd0);
            if (pc_valid && pc_ready) begin
                mmu_q.push_back('{pc, cyc + mmu_lat});
                n_issued++;
            end
            if (redirect_valid) begin
                chk("no_issue_on_redirect", {31'b0, pc_valid}, 32'd0);
                exp_q.delete();
                model_pc = redirect_pc & 32'hffff_fffc;
            end else if (pc_valid && pc_ready) begin
                chk("req_pc", pc, model_pc);
                exp_q.push_back(model_pc);
                model_pc = model_pc + 32'd4;
            end
        end
    end

    task automatic cyc_wait(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_redirect(input logic [31:0] a);
        redirect_valid = 1'b1;
        redirect_pc    = a;
        cyc_wait(1);
        redirect_valid = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        #1;
        chk({tag, "_pc"}, pc, 32'd0);
        chk({tag, "_pc_valid"}, {31'b0, pc_valid}, 32'd0);
        chk({tag, "_o_valid"}, {31'b0, o_valid}, 32'd0);
        chk({tag, "_o_pc"}, o_pc, 32'd0);
        chk({tag, "_o_inst"}, o_inst, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned base;
        int unsigned dbase;

        rst = 1'b1;
        cyc_wait(3);
        check_reset("reset");
        rst = 1'b0;
        o_ready = 1'b1;
        pc_ready = 1'b1;
        cyc_wait(3);
        chk("idle_no_issue", {31'b0, pc_valid}, 32'd0);

        // Sequential streaming with a 1-cycle MMU.
        dbase = n_deliv;
        do_redirect(32'h0000_1000);
        cyc_wait(30);
        chk("stream_delivers", {31'b0, (n_deliv - dbase) >= 20}, 32'd1);

        // Credit limit with decode stalled.
        o_ready = 1'b0;
        do_redirect(32'h0000_4000);
        base = n_issued;
        cyc_wait(20);
        chk("credit_issue_count", n_issued - base, 32'd4);
        chk("credit_pc_valid_low", {31'b0, pc_valid}, 32'd0);
        chk("credit_o_valid", {31'b0, o_valid}, 32'd1);
        base = n_issued;
        o_ready = 1'b1;
        cyc_wait(1);
        o_ready = 1'b0;
        cyc_wait(15);
        chk("one_pop_one_issue", n_issued - base, 32'd1);

        // Redirect with several stale requests in flight (3-cycle MMU).
        o_ready = 1'b1;
        mmu_lat = 3;
        do_redirect(32'h0000_1000);
        cyc_wait(4);
        do_redirect(32'h0000_2000);
        cyc_wait(30);

        // Redirect during steady flow: response, transfer and redirect coincide.
        mmu_lat = 1;
        do_redirect(32'h0000_3000);
        cyc_wait(10);
        do_redirect(32'h0000_5000);
        cyc_wait(10);

        // Back-to-back redirects, second one misaligned.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_6000;
        cyc_wait(1);
        redirect_pc    = 32'h0000_7003;
        cyc_wait(1);
        redirect_valid = 1'b0;
        cyc_wait(15);

        // Address wrap at the top of the address space.
        do_redirect(32'hffff_fff8);
        cyc_wait(12);

        // Randomised traffic.
        for (int unsigned i = 0; i < 500; i++) begin
            pc_ready = ($urandom_range(0, 3) != 0);
            o_ready  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) halt = ~halt;
            if ($urandom_range(0, 24) == 0) begin
                mmu_lat = $urandom_range(1, 4);
                if ($urandom_range(0, 3) == 0) do_redirect(32'hffff_fff0 | ($urandom & 32'hf));
                else do_redirect($urandom);
            end else begin
                cyc_wait(1);
            end
        end
        halt = 1'b0;
        pc_ready = 1'b1;
        o_ready = 1'b1;
        cyc_wait(20);

        // halt with two requests in flight.
        mmu_lat = 3;
        do_redirect(32'h0000_8000);
        dbase = n_deliv;
        cyc_wait(2);
        halt = 1'b1;
        cyc_wait(15);
        chk("halt_inflight_delivered", n_deliv - dbase, 32'd2);
        chk("halt_buffer_drained", {31'b0, o_valid}, 32'd0);
        chk("halt_scoreboard_empty", exp_q.size(), 32'd0);
        halt = 1'b0;
        mmu_lat = 1;
        cyc_wait(6);

        // Reset mid-stream.
        rst = 1'b1;
        cyc_wait(1);
        check_reset("midreset");
        rst = 1'b0;
        cyc_wait(3);
        chk("post_reset_idle", {31'b0, pc_valid}, 32'd0);

        chk("total_deliveries", {31'b0, n_deliv > 100}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
